mem_req_arbiter: RTL and testbench



---
 rtl/mem_req_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_req_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Round-robin arbiter sharing NumPorts physical memory ports among NumReq
//   requesters. Up to NumPorts valid requests are granted per cycle, starting
//   the scan at the round-robin pointer. A write is held back if an earlier
//   grant in the same cycle is a write to the same address. Read data returns
//   to the owning requester one cycle after the grant.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   req_valid_i      per-requester request pending
//   req_ready_o      per-requester grant (combinational, transfer completes)
//   req_addr_i       per-requester address
//   req_we_i         per-requester write enable (1 = write)
//   req_wdata_i      per-requester write data (signed)
//   rsp_valid_o      per-requester read response valid (registered pulse)
//   rsp_rdata_o      per-requester read data (registered, held otherwise)
//   mem_addr_o       per-port memory address (0 when port unused)
//   mem_we_o         per-port memory write enable (0 when port unused)
//   mem_wr_data_o    per-port memory write data (0 when port unused)
//   mem_rd_data_i    per-port combinational read data from memory
module mem_req_arbiter #(
  parameter int NumReq    = 8,
  parameter int NumPorts  = 2,
  parameter int DataWidth = 8,
  parameter int DataDepth = 4096,
  parameter int AddrWidth = (DataDepth <= 1) ? 1 : $clog2(DataDepth),
  parameter int IdxWidth  = $clog2(NumReq)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  logic [AddrWidth-1:0]        req_addr_i    [NumReq],
  input  logic [NumReq-1:0]           req_we_i,
  input  logic signed [DataWidth-1:0] req_wdata_i   [NumReq],
  output logic [NumReq-1:0]           rsp_valid_o,
  output logic signed [DataWidth-1:0] rsp_rdata_o   [NumReq],
  output logic [AddrWidth-1:0]        mem_addr_o    [NumPorts],
  output logic [NumPorts-1:0]         mem_we_o,
  output logic signed [DataWidth-1:0] mem_wr_data_o [NumPorts],
  input  logic signed [DataWidth-1:0] mem_rd_data_i [NumPorts]
);

  localparam int          PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned NR    = NumReq;
  localparam int unsigned NP    = NumPorts;

  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic [PortW-1:0]    port_sel [NumReq];   // port carrying each granted requester

  // Scan working variables (written only by the grant process).
  int unsigned         scan_cnt;
  int unsigned         scan_pos;
  logic [IdxWidth-1:0] scan_r;
  logic [IdxWidth-1:0] last_idx;
  logic                any_grant;
  logic                conflict;

  // Grant scan: visit requesters ptr, ptr+1, ... (mod NumReq). The ports
  // already assigned in this scan double as the record of earlier grants,
  // so the write-conflict test simply compares against them.
  always_comb begin
    req_ready_o = '0;
    mem_we_o    = '0;
    for (int unsigned p = 0; p < NP; p++) begin
      mem_addr_o[p]    = '0;
      mem_wr_data_o[p] = '0;
    end
    for (int unsigned j = 0; j < NR; j++) begin
      port_sel[j] = '0;
    end
    scan_cnt  = 0;
    scan_pos  = 0;
    scan_r    = '0;
    last_idx  = '0;
    any_grant = 1'b0;
    conflict  = 1'b0;

    for (int unsigned i = 0; i < NR; i++) begin
      scan_pos = 32'(ptr_q) + i;
      if (scan_pos >= NR) begin
        scan_pos = scan_pos - NR;
      end
      scan_r   = IdxWidth'(scan_pos);
      conflict = 1'b0;
      if (req_we_i[scan_r]) begin
        for (int unsigned p = 0; p < NP; p++) begin
          if ((p < scan_cnt) && mem_we_o[p] && (mem_addr_o[p] == req_addr_i[scan_r])) begin
            conflict = 1'b1;
          end
        end
      end
      if (req_valid_i[scan_r] && (scan_cnt < NP) && !conflict) begin
        for (int unsigned p = 0; p < NP; p++) begin
          if (p == scan_cnt) begin
            mem_addr_o[p]    = req_addr_i[scan_r];
            mem_we_o[p]      = req_we_i[scan_r];
            mem_wr_data_o[p] = req_wdata_i[scan_r];
            port_sel[scan_r] = PortW'(p);
          end
        end
        req_ready_o[scan_r] = 1'b1;
        scan_cnt  = scan_cnt + 1;
        last_idx  = scan_r;
        any_grant = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_grant) begin
      if (last_idx == IdxWidth'(NR - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = last_idx + IdxWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      rsp_valid_o <= '0;
      for (int unsigned j = 0; j < NR; j++) begin
        rsp_rdata_o[j] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int unsigned j = 0; j < NR; j++) begin
        if (req_ready_o[j] && !req_we_i[j]) begin
          rsp_valid_o[j] <= 1'b1;
          rsp_rdata_o[j] <= mem_rd_data_i[port_sel[j]];
        end else begin
          rsp_valid_o[j] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter (NumReq=8, NumPorts=2, DataWidth=8,
// DataDepth=4096) with a behavioural memory attached to the ports.
module tb_mem_req_arbiter;

  localparam int NR = 8;
  localparam int NP = 2;
  localparam int DW = 8;
  localparam int AW = 12;

  logic                 clk_i;
  logic                 rst_ni;
  logic [NR-1:0]        req_valid_i;
  logic [NR-1:0]        req_ready_o;
  logic [AW-1:0]        req_addr_i    [NR];
  logic [NR-1:0]        req_we_i;
  logic signed [DW-1:0] req_wdata_i   [NR];
  logic [NR-1:0]        rsp_valid_o;
  logic signed [DW-1:0] rsp_rdata_o   [NR];
  logic [AW-1:0]        mem_addr_o    [NP];
  logic [NP-1:0]        mem_we_o;
  logic signed [DW-1:0] mem_wr_data_o [NP];
  logic signed [DW-1:0] mem_rd_data_i [NP];

  logic signed [DW-1:0] mem [4096];

  int checks = 0;
  int errors = 0;
  int waited;
  logic granted;

  mem_req_arbiter #(
    .NumReq    (NR),
    .NumPorts  (NP),
    .DataWidth (DW),
    .DataDepth (4096)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_we_i      (req_we_i),
    .req_wdata_i   (req_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .mem_addr_o    (mem_addr_o),
    .mem_we_o      (mem_we_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_rd_data_i (mem_rd_data_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Memory: combinational read, write on the rising edge.
  always_comb begin
    for (int p = 0; p < NP; p++) mem_rd_data_i[p] = mem[mem_addr_o[p]];
  end
  always @(posedge clk_i) begin
    for (int p = 0; p < NP; p++) if (mem_we_o[p]) mem[mem_addr_o[p]] <= mem_wr_data_o[p];
  end

  function automatic int pre(input int a);
    logic signed [DW-1:0] b;
    b = DW'(a * 37 + 11);
    return int'(b);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_req();
    req_valid_i = '0;
    req_we_i    = '0;
    for (int r = 0; r < NR; r++) begin
      req_addr_i[r]  = '0;
      req_wdata_i[r] = '0;
    end
  endtask

  task automatic set_rd(input int r, input int a);
    req_valid_i[r] = 1'b1;
    req_we_i[r]    = 1'b0;
    req_addr_i[r]  = AW'(a);
  endtask

  task automatic set_wr(input int r, input int a, input int d);
    req_valid_i[r] = 1'b1;
    req_we_i[r]    = 1'b1;
    req_addr_i[r]  = AW'(a);
    req_wdata_i[r] = DW'(d);
  endtask

  task automatic all_read();
    clear_req();
    for (int r = 0; r < NR; r++) set_rd(r, 'h40 + r);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = DW'(pre(i));
    mem[12'h100] = 8'sd2;
    clear_req();
    rst_ni = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_valid", int'(rsp_valid_o), 0);
    chk("rst_rdata0", int'(rsp_rdata_o[0]), 0);
    chk("rst_idle_ready", int'(req_ready_o), 0);
    chk("rst_idle_addr0", int'(mem_addr_o[0]), 0);
    tick();
    tick();
    rst_ni = 1'b1;

    // Round robin, all reading
    all_read();
    #2;
    chk("rr0_ready", int'(req_ready_o), 'h03);
    chk("rr0_addr0", int'(mem_addr_o[0]), 'h40);
    chk("rr0_addr1", int'(mem_addr_o[1]), 'h41);
    tick();
    chk("rr0_rsp", int'(rsp_valid_o), 'h03);
    chk("rr0_rd0", int'(rsp_rdata_o[0]), pre('h40));
    chk("rr0_rd1", int'(rsp_rdata_o[1]), pre('h41));
    #2;
    chk("rr1_ready", int'(req_ready_o), 'h0C);
    tick();
    chk("rr1_rsp", int'(rsp_valid_o), 'h0C);
    chk("rr1_rd3", int'(rsp_rdata_o[3]), pre('h43));
    #2;
    chk("rr2_ready", int'(req_ready_o), 'h30);
    tick();
    chk("rr2_rsp", int'(rsp_valid_o), 'h30);
    #2;
    chk("rr3_ready", int'(req_ready_o), 'hC0);
    tick();
    chk("rr3_rsp", int'(rsp_valid_o), 'hC0);
    chk("rr3_rd7", int'(rsp_rdata_o[7]), pre('h47));
    #2;
    chk("rr4_ready", int'(req_ready_o), 'h03);
    tick();
    chk("rr4_rsp", int'(rsp_valid_o), 'h03);

    // Reset asserted mid-stream (ptr is 2 here)
    rst_ni = 1'b0;
    #1;
    chk("mrst_valid", int'(rsp_valid_o), 0);
    chk("mrst_rdata0", int'(rsp_rdata_o[0]), 0);
    chk("mrst_rdata1", int'(rsp_rdata_o[1]), 0);
    chk("mrst_ready", int'(req_ready_o), 'h03);
    tick();
    chk("mrst_no_rsp", int'(rsp_valid_o), 0);
    rst_ni = 1'b1;
    #2;
    chk("post_rst_ready", int'(req_ready_o), 'h03);
    chk("post_rst_addr1", int'(mem_addr_o[1]), 'h41);
    tick();
    chk("post_rst_rsp", int'(rsp_valid_o), 'h03);
    chk("post_rst_rd0", int'(rsp_rdata_o[0]), pre('h40));

    // All idle: ports zeroed, no responses, ptr holds at 2
    clear_req();
    #2;
    chk("idle_ready", int'(req_ready_o), 0);
    chk("idle_addr0", int'(mem_addr_o[0]), 0);
    chk("idle_we", int'(mem_we_o), 0);
    tick();
    chk("idle_rsp", int'(rsp_valid_o), 0);
    chk("idle_hold_rd0", int'(rsp_rdata_o[0]), pre('h40));
    all_read();
    #2;
    chk("idle_ptr_held", int'(req_ready_o), 'h0C);

    // Sparse requests and wrap
    clear_req();
    set_rd(7, 'h47);
    #2;
    chk("sp7_ready", int'(req_ready_o), 'h80);
    chk("sp7_addr0", int'(mem_addr_o[0]), 'h47);
    chk("sp7_addr1", int'(mem_addr_o[1]), 0);
    tick();
    chk("sp7_rsp", int'(rsp_valid_o), 'h80);
    clear_req();
    set_rd(3, 'h43);
    #2;
    chk("sp3_ready", int'(req_ready_o), 'h08);
    chk("sp3_addr0", int'(mem_addr_o[0]), 'h43);
    chk("sp3_addr1", int'(mem_addr_o[1]), 0);
    chk("sp3_we", int'(mem_we_o), 0);
    tick();
    chk("sp3_rd3", int'(rsp_rdata_o[3]), pre('h43));
    all_read();
    #2;
    chk("ptr_is_4", int'(req_ready_o), 'h30);
    clear_req();
    set_rd(7, 'h47);
    tick();   // ptr wraps to 0

    // Write collision
    clear_req();
    set_wr(0, 'h010, 5);
    set_wr(1, 'h010, -3);
    set_rd(2, 'h020);
    #2;
    chk("wc_ready", int'(req_ready_o), 'h05);
    chk("wc_we", int'(mem_we_o), 'h1);
    chk("wc_wdata0", int'(mem_wr_data_o[0]), 5);
    chk("wc_addr1", int'(mem_addr_o[1]), 'h020);
    tick();
    chk("wc_rsp", int'(rsp_valid_o), 'h04);
    chk("wc_rd2", int'(rsp_rdata_o[2]), pre('h020));
    chk("wc_mem_a", int'(mem[12'h010]), 5);
    clear_req();
    set_wr(1, 'h010, -3);
    #2;
    chk("wc2_ready", int'(req_ready_o), 'h02);
    chk("wc2_wdata0", int'(mem_wr_data_o[0]), -3);
    tick();
    chk("wc2_rsp", int'(rsp_valid_o), 0);
    chk("wc2_mem", int'(mem[12'h010]), -3);

    // Same-cycle read/write to one address (ptr is 2)
    clear_req();
    set_wr(0, 'h100, 7);
    set_rd(1, 'h100);
    #2;
    chk("rw_ready", int'(req_ready_o), 'h03);
    chk("rw_we", int'(mem_we_o), 'h1);
    tick();
    chk("rw_rsp", int'(rsp_valid_o), 'h02);
    chk("rw_old", int'(rsp_rdata_o[1]), 2);
    clear_req();
    set_rd(1, 'h100);
    tick();
    chk("rw_new", int'(rsp_rdata_o[1]), 7);

    // Fairness: 0..6 saturate, 7 raises valid (ptr is 2)
    all_read();
    waited  = 0;
    granted = 1'b0;
    for (int c = 0; c < 4 && !granted; c++) begin
      #2;
      waited++;
      if (req_ready_o[7]) granted = 1'b1;
      else tick();
    end
    chk("fair_granted", int'(granted), 1);
    chk("fair_cycles", waited, 3);
    chk("fair_ready", int'(req_ready_o), 'hC0);
    tick();
    chk("fair_rsp", int'(rsp_valid_o), 'hC0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
